alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Accepts one operation per handshake (code plus two operands) and returns a registered result.
- Single-cycle ops complete in 1 cycle; MUL uses an iterative shift-add engine and takes WIDTH cycles.
- Sits in the EX stage; busy_o feeds the hazard unit to stall IF/ID while a MUL is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount bits taken from data2_i; must equal log2(WIDTH).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  operation request valid.
- in_ready_o  output  1  unit can accept a request this cycle.
- ALUCtrl_i  input  3  operation code: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 SRA, 111 reserved (executes as ADD).
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B; low SHAMT_W bits are the shift amount.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- data_o  output  WIDTH  result.
- zero_o  output  1  high when data_o == 0; qualified by out_valid_o.
- busy_o  output  1  high while in state MUL.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, out_valid_o=0, data_o=0, zero_o=1, busy_o=0, multiplier registers cleared. in_ready_o is 1 from the first edge after reset deasserts.
- States:
  - IDLE: no op in flight.
  - MUL: multiplying.
  - HOLD: result valid, waiting for out_ready_i.
- in_ready_o = (state==IDLE) or (state==HOLD and out_ready_i). The accept path is combinational on out_ready_i. No combinational path from in_valid_i to in_ready_o.
- Accept occurs when in_valid_i and in_ready_o are both high at a clock edge.
- Non-MUL accept:
  - Result registered at that edge; out_valid_o=1 next cycle (latency 1); state becomes HOLD.
  - AND/XOR are bitwise. ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLL: data1 << data2[SHAMT_W-1:0].
  - SRA: arithmetic right shift by data2[SHAMT_W-1:0], sign-filled from data1[WIDTH-1].
- MUL accept:
  - Latch multiplicand=data1, multiplier=data2, accumulator=0, counter=0; state becomes MUL. out_valid_o drops to 0 if a HOLD result was consumed in the same cycle.
  - Each MUL cycle: if multiplier[0], accumulator += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After WIDTH iterations: data_o = low WIDTH bits of the product (signed and unsigned identical); state becomes HOLD; out_valid_o=1.
  - Total latency is WIDTH+1 cycles from the accept edge to the first cycle with out_valid_o=1.
  - No early termination.
- HOLD:
  - data_o, zero_o and out_valid_o are stable until out_valid_o and out_ready_i are both high.
  - On release with no new accept: state becomes IDLE, out_valid_o=0, data_o holds its last value.
  - Release plus accept in the same cycle: the new op starts. Back-to-back single-cycle ops sustain 1 op per cycle.
- In MUL, in_ready_o=0 and out_valid_o=0. in_valid_i is ignored and its request is not lost; the requester must hold it.
- Reset asserted mid-MUL aborts the op immediately; no result is produced.
- Reserved code 111 behaves exactly as 011.
- Operands are sampled only at accept; changes afterward have no effect.

Test Plan:
- Reset, then ADD 0x00000005 + 0xFFFFFFFB -> one cycle later out_valid_o=1, data_o=0x00000000, zero_o=1; held until out_ready_i=1.
- SUB 3-5, SLL 0x1 by 31, SRA 0x80000000 by 4 issued back-to-back with out_ready_i=1 -> results 0xFFFFFFFE, 0x80000000, 0xF8000000 on consecutive cycles; in_ready_o stays 1.
- MUL 0x00010003 * 0x00020005 -> busy_o=1 and in_ready_o=0 for 32 cycles; out_valid_o rises on cycle 33; data_o=0x000B000F.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> data_o=0x00000001. Then XOR 0xA5A5A5A5 ^ 0xFFFF0000 requested while out_ready_i=0 -> in_ready_o=0; MUL result held; XOR accepted the cycle out_ready_i=1, result 0x5A5AA5A5.
- Assert rst_i at MUL cycle 10 -> out_valid_o=0, busy_o=0 asynchronously; the next op (AND 0xF0F0F0F0 & 0x0FF00FF0 = 0x00F000F0) completes normally.
- Code 111 with operands 7 and 9 -> data_o=0x00000010, identical to code 011.

Source files
------------

// File: rtl/alu_exec_if.sv
// Request/response bundle between the EX-stage issue logic and the ALU
// execution unit. Names are seen from the execution unit's side.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;

  modport master (
    output in_valid_i, ALUCtrl_i, data1_i, data2_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, zero_o, busy_o
  );

  modport slave (
    input  in_valid_i, ALUCtrl_i, data1_i, data2_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, zero_o, busy_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/shift/add ops, plus an iterative
// shift-add multiplier that holds the pipeline via busy_o.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_exec_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam logic [SHAMT_W-1:0] LAST =
    SHAMT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic               in_ready;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_nxt;

  assign in_ready = (state_q == S_IDLE) ||
                    (state_q == S_HOLD && bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;
  assign shamt    = bus.data2_i[SHAMT_W-1:0];

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == S_HOLD);
  assign bus.busy_o      = (state_q == S_MUL);
  assign bus.data_o      = data_q;
  assign bus.zero_o      = (data_q == '0);

  always_comb begin
    alu_res = bus.data1_i + bus.data2_i;
    unique case (bus.ALUCtrl_i)
      OP_AND: alu_res = bus.data1_i & bus.data2_i;
      OP_XOR: alu_res = bus.data1_i ^ bus.data2_i;
      OP_SLL: alu_res = bus.data1_i << shamt;
      OP_ADD: alu_res = bus.data1_i + bus.data2_i;
      OP_SUB: alu_res = bus.data1_i - bus.data2_i;
      OP_SRA: alu_res = WIDTH'($signed(bus.data1_i) >>> shamt);
      OP_MUL: alu_res = '0;
      OP_RSV: alu_res = bus.data1_i + bus.data2_i;
      default: alu_res = bus.data1_i + bus.data2_i;
    endcase
  end

  assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = bus.data1_i;
            mplier_d = bus.data2_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = S_HOLD;
            data_d  = alu_res;
          end
        end else if (state_q == S_HOLD && bus.out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last iteration commits the product straight into the result.
        if (cnt_q == LAST) begin
          state_d = S_HOLD;
          data_d  = acc_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, streaming,
// multiply latency, hold/backpressure, async reset abort.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid_i = 1'b1;
    bus.ALUCtrl_i  = op;
    bus.data1_i    = a;
    bus.data2_i    = b;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.ALUCtrl_i   = 3'b000;
    bus.data1_i     = '0;
    bus.data2_i     = '0;
    bus.out_ready_i = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_data", bus.data_o, 32'h0);
    check("rst_zero", 32'(bus.zero_o), 32'd1);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("idle_ready", 32'(bus.in_ready_o), 32'd1);

    // ADD wrapping to zero, then held under backpressure
    issue(3'b011, 32'h5, 32'hFFFF_FFFB);
    step();
    bus.in_valid_i = 1'b0;
    check("add_valid", 32'(bus.out_valid_o), 32'd1);
    check("add_data", bus.data_o, 32'h0);
    check("add_zero", 32'(bus.zero_o), 32'd1);
    check("hold_ready", 32'(bus.in_ready_o), 32'd0);
    step();
    step();
    check("add_held_valid", 32'(bus.out_valid_o), 32'd1);
    check("add_held_data", bus.data_o, 32'h0);
    bus.out_ready_i = 1'b1;
    #1;
    check("rel_ready", 32'(bus.in_ready_o), 32'd1);

    // back-to-back stream while releasing the ADD result
    issue(3'b100, 32'd3, 32'd5);
    step();
    check("sub_data", bus.data_o, 32'hFFFF_FFFE);
    check("sub_zero", 32'(bus.zero_o), 32'd0);
    check("sub_ready", 32'(bus.in_ready_o), 32'd1);
    issue(3'b010, 32'h1, 32'd31);
    step();
    check("sll_data", bus.data_o, 32'h8000_0000);
    check("sll_ready", 32'(bus.in_ready_o), 32'd1);
    issue(3'b110, 32'h8000_0000, 32'd4);
    step();
    check("sra_data", bus.data_o, 32'hF800_0000);
    check("sra_valid", 32'(bus.out_valid_o), 32'd1);
    bus.in_valid_i = 1'b0;
    step();
    check("idle_valid", 32'(bus.out_valid_o), 32'd0);
    check("idle_data", bus.data_o, 32'hF800_0000);

    // MUL latency; operands changed after accept must not matter
    bus.out_ready_i = 1'b0;
    issue(3'b101, 32'h0001_0003, 32'h0002_0005);
    step();
    bus.in_valid_i = 1'b0;
    bus.data1_i    = 32'hDEAD_BEEF;
    bus.data2_i    = 32'h1234_5678;
    for (int i = 1; i <= 32; i++) begin
      check($sformatf("mul_busy%0d", i), 32'(bus.busy_o), 32'd1);
      check($sformatf("mul_rdy%0d", i), 32'(bus.in_ready_o), 32'd0);
      check($sformatf("mul_vld%0d", i), 32'(bus.out_valid_o), 32'd0);
      step();
    end
    check("mul_done_valid", 32'(bus.out_valid_o), 32'd1);
    check("mul_done_busy", 32'(bus.busy_o), 32'd0);
    check("mul_data", bus.data_o, 32'h000B_000F);

    // release MUL result and accept next MUL in the same cycle
    bus.out_ready_i = 1'b1;
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    bus.out_ready_i = 1'b0;
    check("mul2_busy", 32'(bus.busy_o), 32'd1);
    check("mul2_vld", 32'(bus.out_valid_o), 32'd0);
    issue(3'b001, 32'hA5A5_A5A5, 32'hFFFF_0000);
    repeat (32) step();
    check("mul2_valid", 32'(bus.out_valid_o), 32'd1);
    check("mul2_data", bus.data_o, 32'h1);
    check("xor_blocked", 32'(bus.in_ready_o), 32'd0);
    step();
    check("mul2_held", bus.data_o, 32'h1);
    check("mul2_held_vld", 32'(bus.out_valid_o), 32'd1);
    bus.out_ready_i = 1'b1;
    #1;
    check("xor_ready", 32'(bus.in_ready_o), 32'd1);
    step();
    bus.in_valid_i = 1'b0;
    check("xor_data", bus.data_o, 32'h5A5A_A5A5);
    check("xor_valid", 32'(bus.out_valid_o), 32'd1);
    step();

    // reset during MUL aborts it
    issue(3'b101, 32'd3, 32'd5);
    step();
    bus.in_valid_i = 1'b0;
    repeat (9) step();
    check("abort_pre_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_valid", 32'(bus.out_valid_o), 32'd0);
    step();
    rst = 1'b0;
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    step();
    bus.in_valid_i = 1'b0;
    check("and_data", bus.data_o, 32'h00F0_00F0);
    check("and_valid", 32'(bus.out_valid_o), 32'd1);
    step();
    repeat (30) step();
    check("no_ghost_valid", 32'(bus.out_valid_o), 32'd0);

    // reserved code executes as ADD
    issue(3'b111, 32'd7, 32'd9);
    step();
    check("rsv_data", bus.data_o, 32'h10);
    issue(3'b011, 32'd7, 32'd9);
    step();
    bus.in_valid_i = 1'b0;
    check("add79_data", bus.data_o, 32'h10);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
